// File: rtl/phase_gen.sv
// Two-phase non-overlapping clock generator: synchronises an async PWM command
// and drives complementary phases separated by a programmable dead time.
`timescale 1ns/1ps
module phase_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int DEAD_W      = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic V_PWM_C,
  output logic phi1,
  output logic phi2
);

  typedef enum logic [2:0] {OFF, DT1, PH1, DT2, PH2} state_t;

  localparam int CNT_MAX  = (2 ** DEAD_W) - 1;
  localparam int OFF_LD_I = SYNC_STAGES + DEAD_CYCLES - 2;
  localparam logic [DEAD_W-1:0] DT_LOAD  = DEAD_W'(DEAD_CYCLES - 1);
  // Leaving OFF, the synchroniser still holds reset zeros rather than real
  // samples; the first dead time is stretched by the fill depth to cover that.
  localparam logic [DEAD_W-1:0] OFF_LOAD = DEAD_W'((OFF_LD_I > CNT_MAX) ? CNT_MAX : OFF_LD_I);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_n;
  logic [DEAD_W-1:0]      cnt, cnt_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], V_PWM_C};
  end

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      cnt   <= '0;
      phi1  <= 1'b0;
      phi2  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      phi1  <= (state_n == PH1);
      phi2  <= (state_n == PH2);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      OFF: begin
        cnt_n   = OFF_LOAD;
        state_n = s ? DT1 : DT2;
      end
      DT1: begin
        if (!s) begin
          state_n = DT2;
          cnt_n   = DT_LOAD;
        end else if (cnt == '0) begin
          state_n = PH1;
        end else begin
          cnt_n = cnt - DEAD_W'(1);
        end
      end
      DT2: begin
        if (s) begin
          state_n = DT1;
          cnt_n   = DT_LOAD;
        end else if (cnt == '0) begin
          state_n = PH2;
        end else begin
          cnt_n = cnt - DEAD_W'(1);
        end
      end
      PH1: begin
        if (!s) begin
          state_n = DT2;
          cnt_n   = DT_LOAD;
        end
      end
      PH2: begin
        if (s) begin
          state_n = DT1;
          cnt_n   = DT_LOAD;
        end
      end
      default: state_n = OFF;
    endcase
  end

endmodule

// File: tb/tb_phase_gen.sv
// Bench for phase_gen: three dead-time variants share one command input and are
// compared each cycle against a sliding-window model of the command history.
`timescale 1ns/1ps
module tb_phase_gen;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v = 1'b0;
  logic p1_a, p2_a, p1_b, p2_b, p1_c, p2_c;

  phase_gen #(.SYNC_STAGES(SYNC), .DEAD_W(8), .DEAD_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .V_PWM_C(v), .phi1(p1_a), .phi2(p2_a));
  phase_gen #(.SYNC_STAGES(SYNC), .DEAD_W(8), .DEAD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .V_PWM_C(v), .phi1(p1_b), .phi2(p2_b));
  phase_gen #(.SYNC_STAGES(SYNC), .DEAD_W(8), .DEAD_CYCLES(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .V_PWM_C(v), .phi1(p1_c), .phi2(p2_c));

  always #1 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit hist [0:65535];
  int last_ph [3];
  int low_run [3];

  // Command history: hist[k] is the level sampled at post-reset edge k.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n = 0;
    else if (n < 65535) begin
      n = n + 1;
      hist[n] = v;
    end
  end

  // Level the FSM acts on at edge j; reset zeros stand in before the chain fills.
  function automatic bit obs(int j);
    return (j - SYNC >= 1) ? hist[j - SYNC] : 1'b0;
  endfunction

  // A phase is high after edge n iff the last dc+1 observed levels all request
  // it, and never before the first SYNC+dc edges after reset.
  function automatic logic [1:0] model(int dc);
    bit all1 = 1'b1;
    bit all0 = 1'b1;
    if (!rst_n || n < SYNC + dc) return 2'b00;
    for (int j = n - dc; j <= n; j++) begin
      if (obs(j)) all0 = 1'b0;
      else        all1 = 1'b0;
    end
    return {all0, all1};
  endfunction

  task automatic chk(string tag, logic [1:0] got, logic [1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: {phi2,phi1} got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_int(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic gap_mon(int i, logic a, logic b, int dc);
    int cur;
    if (!rst_n) begin
      last_ph[i] = 0;
      low_run[i] = 0;
    end else if (a | b) begin
      cur = a ? 1 : 2;
      if (last_ph[i] != 0 && last_ph[i] != cur) begin
        checks++;
        assert (low_run[i] >= dc) else begin
          errors++;
          $error("FAIL gap%0d: both-low gap %0d expected >= %0d", i, low_run[i], dc);
        end
      end
      last_ph[i] = cur;
      low_run[i] = 0;
    end else begin
      low_run[i]++;
    end
  endtask

  always @(negedge clk) begin
    chk("model_dc2", {p2_a, p1_a}, model(2));
    chk("model_dc1", {p2_b, p1_b}, model(1));
    chk("model_dc5", {p2_c, p1_c}, model(5));
    gap_mon(0, p1_a, p2_a, 2);
    gap_mon(1, p1_b, p2_b, 1);
    gap_mon(2, p1_c, p2_c, 5);
  end

  task automatic release_seq(string tag);
    v = 1'b0;
    @(posedge clk); #0.5 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk(tag, {p2_a, p1_a}, (k >= 4) ? 2'b10 : 2'b00);
    end
  endtask

  int c1 [3];
  int c2 [3];
  int c0 [3];
  int run;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_hold_a", {p2_a, p1_a}, 2'b00);
    chk("rst_hold_c", {p2_c, p1_c}, 2'b00);
    release_seq("release1");
    repeat (10) @(posedge clk);

    // Command 0->1; edge 0 is the first edge sampling the new level.
    #0.2 v = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); @(negedge clk);
      chk("edge_lat", {p2_a, p1_a}, {(k < 2), (k >= 4)});
    end

    chk("pre_rst", {p2_a, p1_a}, 2'b01);
    @(posedge clk); #0.3 rst_n = 1'b0;
    #0.1;
    chk("async_rst_a", {p2_a, p1_a}, 2'b00);
    chk("async_rst_b", {p2_b, p1_b}, 2'b00);
    chk("async_rst_c", {p2_c, p1_c}, 2'b00);
    repeat (2) @(negedge clk);
    release_seq("release2");

    // Steady PWM with H=10; measure one full period once settled.
    c1 = '{0, 0, 0}; c2 = '{0, 0, 0}; c0 = '{0, 0, 0};
    for (int hp = 0; hp < 6; hp++) begin
      @(posedge clk); #0.2 v = ~v;
      repeat (10) begin
        @(negedge clk);
        if (hp >= 4) begin
          c1[0] += p1_a; c2[0] += p2_a; c0[0] += int'(!(p1_a | p2_a));
          c1[1] += p1_b; c2[1] += p2_b; c0[1] += int'(!(p1_b | p2_b));
          c1[2] += p1_c; c2[2] += p2_c; c0[2] += int'(!(p1_c | p2_c));
        end
      end
    end
    chk_int("pwm_phi1_dc2", c1[0], 8);
    chk_int("pwm_phi2_dc2", c2[0], 8);
    chk_int("pwm_low_dc2",  c0[0], 4);
    chk_int("pwm_phi1_dc1", c1[1], 9);
    chk_int("pwm_phi2_dc1", c2[1], 9);
    chk_int("pwm_low_dc1",  c0[1], 2);
    chk_int("pwm_phi1_dc5", c1[2], 5);
    chk_int("pwm_phi2_dc5", c2[2], 5);
    chk_int("pwm_low_dc5",  c0[2], 10);

    // One-cycle glitch while settled in PH2.
    @(posedge clk); #0.2 v = 1'b0;
    repeat (15) @(posedge clk);
    #0.2 v = 1'b1;
    @(posedge clk); #0.2 v = 1'b0;
    c1 = '{0, 0, 0}; c0 = '{0, 0, 0};
    repeat (16) begin
      @(negedge clk);
      c1[0] += p1_a; c0[0] += int'(!p2_a);
      c1[1] += p1_b; c0[1] += int'(!p2_b);
      c1[2] += p1_c; c0[2] += int'(!p2_c);
    end
    chk_int("glitch_phi1_dc2", c1[0], 0);
    chk_int("glitch_phi1_dc1", c1[1], 0);
    chk_int("glitch_phi1_dc5", c1[2], 0);
    chk_int("glitch_low_dc2", c0[0], 3);
    chk_int("glitch_low_dc1", c0[1], 2);
    chk_int("glitch_low_dc5", c0[2], 6);
    chk_int("glitch_bound_dc2", int'(c0[0] <= SYNC - 1 + 2 + 1), 1);

    // Random command runs with occasional mid-cycle reset pulses.
    run = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk); #0.2;
      if (run == 0) begin
        v = ~v;
        run = $urandom_range(1, 14);
      end
      run--;
      if ($urandom_range(0, 499) == 0) begin
        #0.3 rst_n = 1'b0;
        #0.2;
        chk("rnd_async_rst", {p2_a | p2_b | p2_c, p1_a | p1_b | p1_c}, 2'b00);
        #0.2 rst_n = 1'b1;
      end
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
